// File: rtl/parity_rr_sched.sv
// Round-robin frame scheduler: grants one requester at a time and streams its frame LSB-first
// through an odd/even ones/zeros tracker. Define PSCHED_FIXED_PRIO_EN for fixed lowest-index priority.
module parity_rr_sched #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*WIDTH-1:0]    data_in,
  input  logic [$clog2(WIDTH+1)-1:0] frame_len,
  output logic [NREQ-1:0]          grant,
  output logic                     busy,
  output logic                     bit_out,
  output logic                     bit_valid,
  output logic                     done,
  output logic [1:0]               result_state,
  output logic                     result
);

  // state  | meaning
  // IDLE   | waiting for any req; arbiter picks the winner
  // LOAD   | grant driven; winner's word, length and cleared tracker latched
  // SHIFT  | one frame bit per cycle into the tracker, L cycles
  // REPORT | done pulse with final tracker; pointer advances past winner

  localparam int LW = $clog2(WIDTH + 1);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, REPORT} state_t;

  state_t            state, state_nxt;
  logic [IW-1:0]     win;
  logic [IW-1:0]     ptr;
  logic [IW-1:0]     pick;
  logic [IW-1:0]     ptr_nxt;
  logic [WIDTH-1:0]  sreg;
  logic [WIDTH-1:0]  slice;
  logic [LW-1:0]     cnt;
  logic [LW-1:0]     eff_len;
  logic [1:0]        tracker;

  // Search starts at ptr and wraps; first asserted req wins.
  always_comb begin
    logic [IW:0] sum;
    logic        hit;
    pick = '0;
    hit  = 1'b0;
    sum  = '0;
    for (int i = 0; i < NREQ; i++) begin
      sum = {1'b0, ptr} + (IW+1)'(i);
      if (sum >= (IW+1)'(NREQ))
        sum = sum - (IW+1)'(NREQ);
      if (!hit && req[sum[IW-1:0]]) begin
        hit  = 1'b1;
        pick = sum[IW-1:0];
      end
    end
  end

  always_comb begin
    slice = '0;
    for (int i = 0; i < NREQ; i++)
      if (win == IW'(i))
        slice = data_in[i*WIDTH +: WIDTH];
  end

  always_comb begin
    if (frame_len == '0 || frame_len > LW'(WIDTH))
      eff_len = LW'(WIDTH);
    else
      eff_len = frame_len;
  end

  always_comb begin
`ifdef PSCHED_FIXED_PRIO_EN
    ptr_nxt = '0;
`else
    if (win == IW'(NREQ - 1))
      ptr_nxt = '0;
    else
      ptr_nxt = win + IW'(1);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req) state_nxt = LOAD;
      LOAD:    state_nxt = SHIFT;
      SHIFT:   if (cnt == LW'(1)) state_nxt = REPORT;
      REPORT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      win     <= '0;
      ptr     <= '0;
      sreg    <= '0;
      cnt     <= '0;
      tracker <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (|req)
            win <= pick;
        end
        LOAD: begin
          sreg    <= slice;
          cnt     <= eff_len;
          tracker <= 2'b00;
        end
        SHIFT: begin
          sreg <= sreg >> 1;
          cnt  <= cnt - LW'(1);
          // tracker = {zeros_odd, ones_odd}
          if (sreg[0])
            tracker[0] <= ~tracker[0];
          else
            tracker[1] <= ~tracker[1];
        end
        REPORT: begin
          ptr <= ptr_nxt;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy         = (state != IDLE);
    bit_valid    = (state == SHIFT);
    done         = (state == REPORT);
    bit_out      = bit_valid & sreg[0];
    grant        = busy ? (NREQ'(1) << win) : '0;
    result_state = tracker;
    result       = done & (tracker == 2'b00);
  end

endmodule

// File: tb/tb_parity_rr_sched.sv
// Self-checking bench for parity_rr_sched: directed frames with literal expectations plus
// randomized traffic checked every cycle against a frame-level reference model.
module tb_parity_rr_sched;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int LW    = $clog2(WIDTH + 1);

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] data_in;
  logic [LW-1:0]         frame_len;
  logic [NREQ-1:0]       grant;
  logic                  busy, bit_out, bit_valid, done, result;
  logic [1:0]            result_state;

  int checks = 0;
  int errors = 0;

  parity_rr_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .req(req), .data_in(data_in), .frame_len(frame_len),
    .grant(grant), .busy(busy), .bit_out(bit_out), .bit_valid(bit_valid),
    .done(done), .result_state(result_state), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: position within the current frame (-1 = idle, 0 = load,
  // 1..L = shift bit L-1, L+1 = report) and the round-robin pointer.
  int               m_pos = -1;
  int               m_ptr = 0;
  int               m_win = 0;
  int               m_len = 1;
  int               m_ones, m_c;
  logic             m_hit;
  logic             m_on = 1'b0;
  logic [WIDTH-1:0] m_data = '0;

  logic [NREQ-1:0]  exp_grant;
  logic             exp_busy, exp_valid, exp_done, exp_bit, exp_res;
  logic [1:0]       exp_rs;

  always @(posedge clk) begin
    if (reset) begin
      m_pos = -1;
      m_ptr = 0;
      m_on  = 1'b1;
    end else if (m_pos < 0) begin
      if (req != '0) begin
        m_hit = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
          m_c = (m_ptr + i) % NREQ;
          if (!m_hit && req[m_c]) begin
            m_hit = 1'b1;
            m_win = m_c;
          end
        end
        m_pos = 0;
      end
    end else if (m_pos == 0) begin
      m_data = data_in[m_win*WIDTH +: WIDTH];
      m_len  = (frame_len == 0 || int'(frame_len) > WIDTH) ? WIDTH : int'(frame_len);
      m_pos  = 1;
    end else if (m_pos == m_len + 1) begin
      m_ptr = (m_win + 1) % NREQ;
      m_pos = -1;
    end else begin
      m_pos++;
    end

    exp_busy  = (m_pos >= 0);
    exp_grant = exp_busy ? (NREQ'(1) << m_win) : '0;
    exp_valid = (m_pos >= 1) && (m_pos <= m_len);
    exp_done  = (m_pos >= 1) && (m_pos == m_len + 1);
    exp_bit   = exp_valid ? m_data[m_pos-1] : 1'b0;
    m_ones = 0;
    for (int k = 0; k < m_len; k++)
      m_ones += int'(m_data[k]);
    exp_rs  = {1'((m_len - m_ones) % 2), 1'(m_ones % 2)};
    exp_res = (exp_rs == 2'b00);

    #1;
    if (m_on) begin
      check("m_busy", busy, exp_busy);
      check("m_grant", grant, exp_grant);
      check("m_bit_valid", bit_valid, exp_valid);
      check("m_done", done, exp_done);
      if (exp_valid) check("m_bit_out", bit_out, exp_bit);
      if (exp_done) begin
        check("m_result_state", result_state, exp_rs);
        check("m_result", result, exp_res);
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  // Entered at the negedge of an IDLE cycle with req already set.
  task automatic frame(input string name, input logic [NREQ-1:0] g, input int len,
                       input logic [15:0] bits, input logic [1:0] rs, input logic res);
    step();
    check({name, " load grant"}, grant, g);
    check({name, " load busy"}, busy, 1);
    check({name, " load bit_valid"}, bit_valid, 0);
    for (int k = 0; k < len; k++) begin
      step();
      check({name, " shift bit_valid"}, bit_valid, 1);
      check({name, " shift bit_out"}, bit_out, bits[k]);
      check({name, " shift done"}, done, 0);
    end
    step();
    check({name, " done"}, done, 1);
    check({name, " result_state"}, result_state, rs);
    check({name, " result"}, result, res);
    check({name, " report grant"}, grant, g);
    req = req & ~g;
    step();
    check({name, " gap busy"}, busy, 0);
    check({name, " gap done"}, done, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  logic [1:0] rr_rs  [NREQ];
  logic       rr_res [NREQ];

  initial begin
    reset = 1'b1; req = '0; data_in = '0; frame_len = '0;
    repeat (2) step();
    check("rst grant", grant, 0);
    check("rst busy", busy, 0);
    check("rst bit_valid", bit_valid, 0);
    check("rst bit_out", bit_out, 0);
    check("rst done", done, 0);
    check("rst result_state", result_state, 0);
    check("rst result", result, 0);

    reset = 1'b0;
    req = 4'b0001; data_in = 32'h0000_0003; frame_len = 4'd4;
    frame("single", 4'b0001, 4, 16'h0003, 2'b00, 1'b1);

    req = 4'b0001; data_in = 32'h0000_0001; frame_len = 4'd3;
    frame("odd", 4'b0001, 3, 16'h0001, 2'b01, 1'b0);

    req = 4'b0001; data_in = 32'h0000_00FF; frame_len = 4'd0;
    frame("len0", 4'b0001, 8, 16'h00FF, 2'b00, 1'b1);

    // Round-robin: slices 00,01,02,03 at L=2
    rr_rs[0] = 2'b00; rr_res[0] = 1'b1;
    rr_rs[1] = 2'b11; rr_res[1] = 1'b0;
    rr_rs[2] = 2'b11; rr_res[2] = 1'b0;
    rr_rs[3] = 2'b00; rr_res[3] = 1'b1;
    do_reset();
    req = 4'b1111; data_in = 32'h0302_0100; frame_len = 4'd2;
    for (int i = 0; i < NREQ; i++)
      frame("rr", NREQ'(1) << i, 2, 16'(i), rr_rs[i], rr_res[i]);

    do_reset();
    req = 4'b0001; data_in = 32'h00AA_00AA; frame_len = 4'd8;
    step(); step(); step();
    reset = 1'b1; req = 4'b0100;
    step();
    check("abort busy", busy, 0);
    check("abort grant", grant, 0);
    check("abort done", done, 0);
    reset = 1'b0;
    frame("post_reset", 4'b0100, 8, 16'h00AA, 2'b00, 1'b1);

    for (int c = 0; c < 4000; c++) begin
      step();
      reset     = ($urandom_range(0, 299) == 0);
      data_in   = $urandom;
      frame_len = LW'($urandom_range(0, 15));
      for (int i = 0; i < NREQ; i++) begin
        if (req[i]) begin
          if (exp_done && exp_grant[i]) req[i] = 1'b0;
          else if (exp_grant[i] && $urandom_range(0, 49) == 0) req[i] = 1'b0;
          else if (!exp_grant[i] && exp_busy && $urandom_range(0, 29) == 0) req[i] = 1'b0;
        end else if ($urandom_range(0, 5) == 0) begin
          req[i] = 1'b1;
        end
      end
    end
    reset = 1'b0; req = '0;
    repeat (20) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
